// File: rtl/ir_packet_scheduler.sv
// ir_packet_scheduler: arbitrates 10 Hz IR slots between two command sources and supervises the transmitter handshake
module ir_packet_scheduler #(
  parameter int CMD_WIDTH = 4,
  parameter logic [CMD_WIDTH-1:0] IDLE_CMD = '0,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 TICK,
  input  logic                 REQ_A,
  input  logic [CMD_WIDTH-1:0] CMD_A,
  input  logic                 REQ_B,
  input  logic [CMD_WIDTH-1:0] CMD_B,
  input  logic                 TX_DONE,
  output logic                 TX_START,
  output logic [CMD_WIDTH-1:0] TX_CMD,
  output logic [1:0]           GRANT,
  output logic                 OVERRUN,
  output logic                 TIMEOUT_ERR,
  output logic [CNT_WIDTH-1:0] SENT_COUNT
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SV_W = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, ARB, START, WAIT} state_t;
  state_t state;
  logic pending;
  logic [SV_W-1:0] starve;
  logic [WD_W-1:0] watchdog;
  logic b_win, a_win;
  // B takes the slot when A is absent or after A has starved it for STARVE_LIMIT slots
  always_comb begin
    b_win = REQ_B & (~REQ_A | (starve == SV_W'(STARVE_LIMIT)));
    a_win = ~b_win & REQ_A;
  end
  assign TX_START = (state == START);
  // slot sequencer: queues at most one early tick, arbitrates, then watches the transmitter
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      TX_CMD      <= IDLE_CMD;
      GRANT       <= 2'b00;
      OVERRUN     <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      SENT_COUNT  <= '0;
      pending     <= 1'b0;
      starve      <= '0;
      watchdog    <= '0;
    end else begin
      OVERRUN     <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      if (TICK && state != IDLE) begin
        if (pending) OVERRUN <= 1'b1;
        else pending <= 1'b1;
      end
      case (state)
        IDLE: if (TICK || pending) begin
          state   <= ARB;
          pending <= 1'b0;
        end
        ARB: begin
          state  <= START;
          TX_CMD <= b_win ? CMD_B : a_win ? CMD_A : IDLE_CMD;
          GRANT  <= b_win ? 2'b10 : a_win ? 2'b01 : 2'b00;
          starve <= (a_win && REQ_B) ? starve + 1'b1 : '0;
        end
        START: begin
          state    <= WAIT;
          watchdog <= '0;
        end
        default: if (TX_DONE) begin
          state <= IDLE;
          if (~&SENT_COUNT) SENT_COUNT <= SENT_COUNT + 1'b1;
        end else if (watchdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state       <= IDLE;
          TIMEOUT_ERR <= 1'b1;
        end else watchdog <= watchdog + 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_ir_packet_scheduler.sv
// tb_ir_packet_scheduler: scoreboard bench for ir_packet_scheduler
module tb_ir_packet_scheduler;
  logic CLK, RESET, TICK, REQ_A, REQ_B, TX_DONE;
  logic [3:0] CMD_A, CMD_B, TX_CMD;
  logic TX_START, OVERRUN, TIMEOUT_ERR;
  logic [1:0] GRANT;
  logic [15:0] SENT_COUNT;
  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  cmd;
    logic [1:0]  grant;
    logic [15:0] cnt;
    logic [31:0] cyc;
  } ev_t;
  ev_t exp_q[$];
  ev_t act_e, exp_e;
  int cyc = 0;
  int cnt = 0;
  int checks = 0;
  int errors = 0;

  ir_packet_scheduler #(.TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RESET(RESET), .TICK(TICK), .REQ_A(REQ_A), .CMD_A(CMD_A),
    .REQ_B(REQ_B), .CMD_B(CMD_B), .TX_DONE(TX_DONE), .TX_START(TX_START),
    .TX_CMD(TX_CMD), .GRANT(GRANT), .OVERRUN(OVERRUN),
    .TIMEOUT_ERR(TIMEOUT_ERR), .SENT_COUNT(SENT_COUNT)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // monitor: every TX_START / OVERRUN / TIMEOUT_ERR pulse must match the next expected event
  always @(negedge CLK) if (RESET && (TX_START || OVERRUN || TIMEOUT_ERR)) begin
    act_e = '{TX_START ? 2'd0 : OVERRUN ? 2'd1 : 2'd2, TX_CMD, GRANT, SENT_COUNT, cyc};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual kind=%0d cmd=%0h grant=%b cyc=%0d required none", act_e.kind, act_e.cmd, act_e.grant, cyc);
    end else begin
      exp_e = exp_q.pop_front();
      if (act_e !== exp_e) begin
        errors++;
        $display("FAIL event actual kind=%0d cmd=%0h grant=%b cnt=%0d cyc=%0d required kind=%0d cmd=%0h grant=%b cnt=%0d cyc=%0d",
                 act_e.kind, act_e.cmd, act_e.grant, act_e.cnt, act_e.cyc, exp_e.kind, exp_e.cmd, exp_e.grant, exp_e.cnt, exp_e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push(input logic [1:0] k, input logic [3:0] c, input logic [1:0] g, input int cy);
    exp_q.push_back('{k, c, g, 16'(cnt), 32'(cy)});
  endfunction

  task automatic pulse_tick();
    TICK = 1;
    step();
    TICK = 0;
  endtask

  task automatic pulse_done();
    TX_DONE = 1;
    step();
    TX_DONE = 0;
  endtask

  // one full slot from IDLE: expect TX_START two cycles after the tick, then DONE after wait_n extra WAIT cycles
  task automatic slot(input logic [3:0] c, input logic [1:0] g, input int wait_n);
    push(2'd0, c, g, cyc + 2);
    pulse_tick();
    step();
    step();
    repeat (wait_n) step();
    pulse_done();
    cnt++;
  endtask

  initial begin
    int t;
    RESET = 0; TICK = 0; REQ_A = 0; REQ_B = 0; TX_DONE = 0; CMD_A = 0; CMD_B = 0;
    step();
    step();
    chk("rst_tx_start", 32'(TX_START), 0);
    chk("rst_tx_cmd", 32'(TX_CMD), 0);
    chk("rst_grant", 32'(GRANT), 0);
    chk("rst_overrun", 32'(OVERRUN), 0);
    chk("rst_timeout", 32'(TIMEOUT_ERR), 0);
    chk("rst_count", 32'(SENT_COUNT), 0);
    RESET = 1;
    REQ_A = 1; CMD_A = 4'h5;
    while (cyc != 10) step();
    slot(4'h5, 2'b01, 0);
    chk("t1_count", 32'(SENT_COUNT), 32'(cnt));
    chk("t1_cmd_hold", 32'(TX_CMD), 32'h5);
    chk("t1_grant_hold", 32'(GRANT), 32'b01);
    REQ_A = 0; CMD_A = 4'h6; CMD_B = 4'h9;
    slot(4'h0, 2'b00, 2);
    chk("t2_count", 32'(SENT_COUNT), 32'(cnt));
    REQ_A = 1; REQ_B = 1; CMD_A = 4'h3; CMD_B = 4'hC;
    slot(4'h3, 2'b01, 1);
    slot(4'h3, 2'b01, 0);
    slot(4'h3, 2'b01, 3);
    slot(4'hC, 2'b10, 0);
    slot(4'h3, 2'b01, 0);
    chk("t3_count", 32'(SENT_COUNT), 32'(cnt));
    REQ_B = 0; CMD_A = 4'h7;
    t = cyc;
    push(2'd0, 4'h7, 2'b01, t + 2);
    push(2'd2, 4'h7, 2'b01, t + 11);
    pulse_tick();
    repeat (14) step();
    chk("t4_count", 32'(SENT_COUNT), 32'(cnt));
    CMD_A = 4'h9;
    t = cyc;
    push(2'd0, 4'h9, 2'b01, t + 2);
    pulse_tick();
    step();
    step();
    pulse_tick();
    step();
    push(2'd1, 4'h9, 2'b01, t + 6);
    pulse_tick();
    step();
    pulse_done();
    cnt++;
    push(2'd0, 4'h9, 2'b01, t + 10);
    step();
    step();
    step();
    pulse_done();
    cnt++;
    chk("t5_count", 32'(SENT_COUNT), 32'(cnt));
    CMD_A = 4'hA;
    push(2'd0, 4'hA, 2'b01, cyc + 2);
    pulse_tick();
    step();
    step();
    step();
    RESET = 0;
    #1;
    chk("t6_tx_start", 32'(TX_START), 0);
    chk("t6_tx_cmd", 32'(TX_CMD), 0);
    chk("t6_grant", 32'(GRANT), 0);
    chk("t6_count", 32'(SENT_COUNT), 0);
    step();
    RESET = 1;
    cnt = 0;
    pulse_done();
    step();
    chk("t6_done_ignored", 32'(SENT_COUNT), 0);
    repeat (3) step();
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
